// File: rtl/draw_pkg.sv
// Shared constants for the sprite draw scheduler: mode encoding, layer
// indices, fixed result colours and the sprite transparency key.
package draw_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_WIN  = 2'd2;
  localparam logic [1:0] MODE_LOSE = 2'd3;

  localparam int LAY_CREDITS = 0;
  localparam int LAY_NAME    = 1;
  localparam int LAY_WALL    = 2;
  localparam int LAY_APPLE   = 3;
  localparam int LAY_HEAD    = 4;
  localparam int LAY_BODY    = 5;

  // Width of the sprite ROM bank select
  localparam int SEL_W = 3;

  localparam logic [11:0] COL_WIN  = 12'h0F0;
  localparam logic [11:0] COL_LOSE = 12'hF00;
  localparam logic [11:0] COL_KEY  = 12'h000;

endpackage

// File: rtl/layer_prio_enc.sv
// Lowest-index-wins priority encoder over the per-layer hit vector.
module layer_prio_enc #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     hit,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sched.sv
// Sprite draw scheduler: game mode FSM, per-pixel layer arbitration onto a
// shared sprite ROM, grass background, 2-cycle compositing pipeline and
// per-frame collision event flags.
module draw_sched import draw_pkg::*; #(
  parameter int NUM_LAYERS = 6,
  parameter int ADDR_W     = 16,
  parameter int PIX_W      = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         start,
  input  logic                         win,
  input  logic                         lose,
  input  logic                         pix_valid,
  input  logic [10:0]                  curr_x,
  input  logic [10:0]                  curr_y,
  input  logic [NUM_LAYERS-1:0]        lay_hit,
  input  logic [NUM_LAYERS*ADDR_W-1:0] lay_addr,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [2:0]                   rom_sel,
  input  logic [PIX_W-1:0]             rom_data,
  output logic [11:0]                  grass_addr,
  input  logic [PIX_W-1:0]             grass_data,
  output logic                         out_valid,
  output logic [3:0]                   draw_r,
  output logic [3:0]                   draw_g,
  output logic [3:0]                   draw_b,
  output logic [1:0]                   mode,
  output logic [2:0]                   evt,
  output logic                         evt_valid
);

  logic [1:0]            mode_nxt;
  logic [NUM_LAYERS-1:0] en_hit;
  logic [SEL_W-1:0]      win_idx;
  logic                  win_any;
  logic [ADDR_W-1:0]     win_addr;
  logic [2:0]            evt_raw;
  logic [2:0]            evt_add;
  logic [2:0]            evt_acc;
  logic                  vld_p1;
  logic                  vld_p2;
  logic                  hit_p1;
  logic                  hit_p2;
  logic [1:0]            mode_p1;
  logic [1:0]            mode_p2;
  logic [PIX_W-1:0]      pix_col;
  logic                  unused_coord;

  // Only the low 6 bits of each coordinate address the wrapping grass tile
  assign unused_coord = ^{curr_x[10:6], curr_y[10:6]};

  function automatic logic [NUM_LAYERS-1:0] layer_mask(input logic [1:0] m);
    logic [NUM_LAYERS-1:0] msk;
    msk = '0;
    case (m)
      MODE_IDLE: begin
        msk[LAY_CREDITS] = 1'b1;
        msk[LAY_NAME]    = 1'b1;
      end
      MODE_PLAY: msk = '1;
      default:   msk = '0;
    endcase
    return msk;
  endfunction

  function automatic logic [PIX_W-1:0] compose(input logic [1:0]       m,
                                               input logic             hit,
                                               input logic [PIX_W-1:0] rom,
                                               input logic [PIX_W-1:0] grass);
    if (m == MODE_WIN)
      return COL_WIN;
    if (m == MODE_LOSE)
      return COL_LOSE;
    if (hit && (rom != COL_KEY))
      return rom;
    return grass;
  endfunction

  // Next mode; only a frame_start cycle may move the FSM
  always_comb begin
    mode_nxt = mode;
    if (frame_start) begin
      case (mode)
        MODE_IDLE: if (start) mode_nxt = MODE_PLAY;
        MODE_PLAY: begin
          if (lose)     mode_nxt = MODE_LOSE;
          else if (win) mode_nxt = MODE_WIN;
        end
        MODE_WIN, MODE_LOSE: if (!win && !lose) mode_nxt = MODE_IDLE;
        default:   mode_nxt = MODE_IDLE;
      endcase
    end
  end

  // Mode register
  always_ff @(posedge clk) begin
    if (!rst) mode <= MODE_IDLE;
    else      mode <= mode_nxt;
  end

  // Arbitration uses the post-transition mode so a frame_start pixel sees the new mode
  assign en_hit = lay_hit & layer_mask(mode_nxt);

  layer_prio_enc #(
    .N     (NUM_LAYERS),
    .IDX_W (SEL_W)
  ) u_prio (
    .hit (en_hit),
    .idx (win_idx),
    .any (win_any)
  );

  // Pick the winning layer's ROM address out of the packed address bus
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (win_idx == SEL_W'(i))
        win_addr = lay_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // ---- stage p0 -> p1: issue ROM addresses, addresses hold while idle ----
  // Address outputs and first valid bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr   <= '0;
      rom_sel    <= '0;
      grass_addr <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= pix_valid;
      if (pix_valid) begin
        rom_addr   <= win_addr;
        rom_sel    <= win_idx;
        grass_addr <= {curr_y[5:0], curr_x[5:0]};
      end
    end
  end

  // ---- stage p1 -> p2: wait out the ROM read latency ----
  // Valid bit for the second stage
  always_ff @(posedge clk) begin
    if (!rst) vld_p2 <= 1'b0;
    else      vld_p2 <= vld_p1;
  end

  // Per-pixel side data riding alongside the valid bits
  always_ff @(posedge clk) begin
    hit_p1  <= win_any;
    mode_p1 <= mode_nxt;
    hit_p2  <= hit_p1;
    mode_p2 <= mode_p1;
  end

  assign pix_col = compose(mode_p2, hit_p2, rom_data, grass_data);

  // ---- stage p2 -> out: composite with ROM data now present ----
  // Output pixel, forced to black whenever it is not valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      draw_r    <= '0;
      draw_g    <= '0;
      draw_b    <= '0;
    end else begin
      out_valid <= vld_p2;
      draw_r    <= vld_p2 ? pix_col[11:8] : 4'h0;
      draw_g    <= vld_p2 ? pix_col[7:4]  : 4'h0;
      draw_b    <= vld_p2 ? pix_col[3:0]  : 4'h0;
    end
  end

  // Collision flags come from raw hits, regardless of the enable mask
  assign evt_raw = {lay_hit[LAY_HEAD] & lay_hit[LAY_BODY],
                    lay_hit[LAY_HEAD] & lay_hit[LAY_WALL],
                    lay_hit[LAY_HEAD] & lay_hit[LAY_APPLE]};
  assign evt_add = (pix_valid && (mode_nxt == MODE_PLAY)) ? evt_raw : 3'b000;

  // Sticky per-frame accumulation; frame_start publishes and restarts with this cycle's hits
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt       <= '0;
      evt_valid <= 1'b0;
      evt_acc   <= '0;
    end else begin
      evt_valid <= frame_start;
      if (frame_start) begin
        evt     <= evt_acc;
        evt_acc <= evt_add;
      end else begin
        evt_acc <= evt_acc | evt_add;
      end
    end
  end

endmodule

// File: tb/tb_draw_sched.sv
// Testbench for draw_sched: directed vector table, multi-cycle corner
// sequences and a randomized run against a frame-level reference model.
module tb_draw_sched;

  localparam int NL   = 6;
  localparam int AW   = 16;
  localparam int RCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          start;
  logic          win;
  logic          lose;
  logic          pix_valid;
  logic [10:0]   curr_x;
  logic [10:0]   curr_y;
  logic [NL-1:0] lay_hit;
  logic [NL*AW-1:0] lay_addr;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_sel;
  logic [11:0]   rom_data;
  logic [11:0]   grass_addr;
  logic [11:0]   grass_data;
  logic          out_valid;
  logic [3:0]    draw_r;
  logic [3:0]    draw_g;
  logic [3:0]    draw_b;
  logic [1:0]    mode;
  logic [2:0]    evt;
  logic          evt_valid;

  // ROM models: fixed value for directed vectors, 1-clock synchronous function otherwise
  logic          use_fn;
  logic [11:0]   rom_fix;
  logic [11:0]   grass_fix;
  logic [11:0]   rom_q;
  logic [11:0]   grass_q;

  int tests = 0;
  int fails = 0;

  draw_sched dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .start       (start),
    .win         (win),
    .lose        (lose),
    .pix_valid   (pix_valid),
    .curr_x      (curr_x),
    .curr_y      (curr_y),
    .lay_hit     (lay_hit),
    .lay_addr    (lay_addr),
    .rom_addr    (rom_addr),
    .rom_sel     (rom_sel),
    .rom_data    (rom_data),
    .grass_addr  (grass_addr),
    .grass_data  (grass_data),
    .out_valid   (out_valid),
    .draw_r      (draw_r),
    .draw_g      (draw_g),
    .draw_b      (draw_b),
    .mode        (mode),
    .evt         (evt),
    .evt_valid   (evt_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [2:0] s, input logic [15:0] a);
    if (a[2:0] == 3'd0) return 12'h000;
    return a[15:4] ^ {s, 9'h000};
  endfunction

  function automatic logic [11:0] grass_f(input logic [11:0] a);
    return a ^ 12'hA5A;
  endfunction

  always @(posedge clk) begin
    rom_q   <= rom_f(rom_sel, rom_addr);
    grass_q <= grass_f(grass_addr);
  end

  assign rom_data   = use_fn ? rom_q   : rom_fix;
  assign grass_data = use_fn ? grass_q : grass_fix;

  // Mode rules: 0 IDLE, 1 PLAY, 2 WIN, 3 LOSE, applied at a frame_start
  function automatic int next_m(input int m, input bit s, input bit w, input bit l);
    if (m == 0) return s ? 1 : 0;
    if (m == 1) return l ? 3 : (w ? 2 : 1);
    return (!w && !l) ? 0 : m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cur_m;

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cur_m = next_m(cur_m, start, win, lose);
    chk("mode_at_frame_start", 32'(mode), 32'(cur_m));
  endtask

  task automatic goto_mode(input int target);
    for (int g = 0; g < 6 && cur_m != target; g++) begin
      start = 1'b0;
      case (cur_m)
        0: start = 1'b1;
        1: begin
          win  = (target == 2);
          lose = (target != 2);
        end
        default: begin
          win  = 1'b0;
          lose = 1'b0;
        end
      endcase
      pulse_fs();
    end
    start = 1'b0;
  endtask

  typedef struct {
    int          md;
    logic [5:0]  hit;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] rom;
    logic [11:0] grass;
    bit          chk_sel;
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [11:0] ga;
    logic [11:0] rgb;
  } vec_t;

  vec_t vt [11];

  task automatic apply_vec(input vec_t v);
    pix_valid = 1'b1;
    lay_hit   = v.hit;
    curr_x    = v.x;
    curr_y    = v.y;
    rom_fix   = v.rom;
    grass_fix = v.grass;
    tick();
    pix_valid = 1'b0;
    lay_hit   = '0;
    if (v.chk_sel) begin
      chk("vec_rom_sel", 32'(rom_sel), 32'(v.sel));
      chk("vec_rom_addr", 32'(rom_addr), 32'(v.addr));
    end
    chk("vec_grass_addr", 32'(grass_addr), 32'(v.ga));
    tick();
    chk("vec_out_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("vec_out_valid", 32'(out_valid), 32'd1);
    chk("vec_rgb", 32'({draw_r, draw_g, draw_b}), 32'(v.rgb));
  endtask

  // Randomized-run expectations, indexed by clock edge number
  logic        ex_ov   [RCYC+3];
  logic [11:0] ex_rgb  [RCYC+3];
  logic        ex_ev   [RCYC+3];
  logic [2:0]  ex_evt  [RCYC+3];
  logic [1:0]  ex_mode [RCYC+3];

  initial begin
    int          m;
    int          mn;
    int          w;
    int          e;
    logic [2:0]  acc;
    logic [2:0]  evh;
    logic [5:0]  en;
    logic [11:0] col;
    logic [15:0] a;
    logic [11:0] rv;
    logic [11:0] gv;

    rst = 1'b0; frame_start = 1'b0; start = 1'b0; win = 1'b0; lose = 1'b0;
    pix_valid = 1'b0; curr_x = '0; curr_y = '0; lay_hit = '0;
    lay_addr = {16'hBEEF, 16'h0123, 16'h0456, 16'h2222, 16'h1111, 16'h0001};
    use_fn = 1'b0; rom_fix = '0; grass_fix = '0;
    cur_m = 0;

    // Reset state
    tick();
    tick();
    rst = 1'b1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_sel", 32'(rom_sel), 32'd0);
    chk("rst_grass_addr", 32'(grass_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rgb", 32'({draw_r, draw_g, draw_b}), 32'd0);
    chk("rst_evt", 32'(evt), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);

    // Mode changes only on frame_start edges: 0 -> 1 -> 3
    start = 1'b1;
    pulse_fs();
    start = 1'b0;
    lose  = 1'b1;
    tick();
    chk("mode_hold_no_fs_a", 32'(mode), 32'd1);
    tick();
    chk("mode_hold_no_fs_b", 32'(mode), 32'd1);
    pulse_fs();
    chk("mode_lose", 32'(mode), 32'd3);
    lose = 1'b0;

    // Directed vectors; layer addresses: 0:0001 1:1111 2:2222 3:0456 4:0123 5:BEEF
    vt[0]  = '{0, 6'b001100, 11'd70,   11'd3,    12'h0A5, 12'h2C1, 1'b0, 3'd0, 16'h0000, 12'h0C6, 12'h2C1};
    vt[1]  = '{0, 6'b000110, 11'd1,    11'd1,    12'h3AB, 12'h111, 1'b1, 3'd1, 16'h1111, 12'h041, 12'h3AB};
    vt[2]  = '{0, 6'b111100, 11'd128,  11'd65,   12'h777, 12'h135, 1'b0, 3'd0, 16'h0000, 12'h040, 12'h135};
    vt[3]  = '{1, 6'b011000, 11'd5,    11'd7,    12'h0A5, 12'h111, 1'b1, 3'd3, 16'h0456, 12'h1C5, 12'h0A5};
    vt[4]  = '{1, 6'b001000, 11'd70,   11'd3,    12'h000, 12'h2C1, 1'b1, 3'd3, 16'h0456, 12'h0C6, 12'h2C1};
    vt[5]  = '{1, 6'b000000, 11'd63,   11'd64,   12'h777, 12'h345, 1'b0, 3'd0, 16'h0000, 12'h03F, 12'h345};
    vt[6]  = '{1, 6'b100000, 11'd2047, 11'd2047, 12'hFFF, 12'h001, 1'b1, 3'd5, 16'hBEEF, 12'hFFF, 12'hFFF};
    vt[7]  = '{1, 6'b111111, 11'd0,    11'd0,    12'h123, 12'h456, 1'b1, 3'd0, 16'h0001, 12'h000, 12'h123};
    vt[8]  = '{3, 6'b111111, 11'd9,    11'd9,    12'h0A5, 12'h2C1, 1'b0, 3'd0, 16'h0000, 12'h249, 12'hF00};
    vt[9]  = '{3, 6'b000000, 11'd9,    11'd9,    12'h0A5, 12'h2C1, 1'b0, 3'd0, 16'h0000, 12'h249, 12'hF00};
    vt[10] = '{2, 6'b000011, 11'd20,   11'd40,   12'h0A5, 12'h2C1, 1'b0, 3'd0, 16'h0000, 12'hA14, 12'h0F0};

    for (int i = 0; i < 11; i++) begin
      if (vt[i].md != cur_m) goto_mode(vt[i].md);
      apply_vec(vt[i]);
    end

    // Event flags: head+body in one frame, then an empty frame
    goto_mode(1);
    win = 1'b0; lose = 1'b0;
    pulse_fs();
    pix_valid = 1'b1;
    lay_hit   = 6'b110000;
    tick();
    pix_valid = 1'b0;
    lay_hit   = '0;
    tick();
    pulse_fs();
    chk("evt_self", 32'(evt), 32'b100);
    chk("evt_valid_pulse", 32'(evt_valid), 32'd1);
    tick();
    chk("evt_valid_single", 32'(evt_valid), 32'd0);
    chk("evt_hold", 32'(evt), 32'b100);
    pulse_fs();
    chk("evt_empty_frame", 32'(evt), 32'd0);
    chk("evt_valid_empty", 32'(evt_valid), 32'd1);

    // Reset with pixels in flight
    pix_valid = 1'b1;
    lay_hit   = 6'b001000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    cur_m = 0;
    rst = 1'b1;
    pix_valid = 1'b0;
    lay_hit   = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_out_idle", 32'(out_valid), 32'd0);
    end
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    chk("postrst_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("postrst_lat2", 32'(out_valid), 32'd1);

    // Randomized run against the reference model
    use_fn = 1'b1;
    for (int i = 0; i < RCYC + 3; i++) begin
      ex_ov[i] = 1'b0; ex_rgb[i] = '0; ex_ev[i] = 1'b0; ex_evt[i] = '0; ex_mode[i] = '0;
    end
    start = 1'b0; win = 1'b0; lose = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m = 0; acc = '0; evh = '0;
    for (int c = 0; c < RCYC; c++) begin
      e = c + 1;
      frame_start = (c % 37 == 3) || ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 2) == 0);
      win         = ($urandom_range(0, 5) == 0);
      lose        = ($urandom_range(0, 7) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NL; b++) lay_hit[b] = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NL; b++) lay_addr[b*AW +: AW] = 16'($urandom);
      curr_x = 11'($urandom);
      curr_y = 11'($urandom);

      mn = frame_start ? next_m(m, start, win, lose) : m;
      if (frame_start) begin
        ex_ev[e] = 1'b1;
        evh      = acc;
        acc      = '0;
      end
      ex_evt[e]  = evh;
      ex_mode[e] = 2'(mn);
      if (pix_valid) begin
        en = (mn == 1) ? lay_hit : ((mn == 0) ? (lay_hit & 6'b000011) : 6'b000000);
        gv = grass_f({curr_y[5:0], curr_x[5:0]});
        if (mn == 2)      col = 12'h0F0;
        else if (mn == 3) col = 12'hF00;
        else begin
          col = gv;
          w = -1;
          for (int b = NL - 1; b >= 0; b--) if (en[b]) w = b;
          if (w >= 0) begin
            a  = lay_addr[w*AW +: AW];
            rv = rom_f(3'(w), a);
            if (rv != 12'h000) col = rv;
          end
        end
        ex_ov[e+2]  = 1'b1;
        ex_rgb[e+2] = col;
        if (mn == 1)
          acc = acc | {lay_hit[4] & lay_hit[5], lay_hit[4] & lay_hit[2], lay_hit[4] & lay_hit[3]};
      end
      m = mn;

      tick();
      chk("rnd_out_valid", 32'(out_valid), 32'(ex_ov[e]));
      chk("rnd_rgb", 32'({draw_r, draw_g, draw_b}), ex_ov[e] ? 32'(ex_rgb[e]) : 32'd0);
      chk("rnd_mode", 32'(mode), 32'(ex_mode[e]));
      chk("rnd_evt_valid", 32'(evt_valid), 32'(ex_ev[e]));
      chk("rnd_evt", 32'(evt), 32'(ex_evt[e]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_sched.md
DRAW_SCHED -- requirements
Module: draw_sched

Interface
REQ-001 Param NUM_LAYERS, default 6: number of sprite layers sharing one sprite ROM.
REQ-002 Param ADDR_W, default 16: sprite ROM address width.
REQ-003 Param PIX_W, default 12: pixel width, RGB 4:4:4.
REQ-004 Port clk, input, 1: single clock; one synchronous, active-low reset, all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous active-low reset.
REQ-006 Port frame_start, input, 1: one-cycle pulse at the first pixel of a frame.
REQ-007 Port start, input, 1: level request to leave the title screen.
REQ-008 Ports win and lose, input, 1 each: game result levels.
REQ-009 Port pix_valid, input, 1: curr_x, curr_y and layer inputs are valid this cycle.
REQ-010 Ports curr_x and curr_y, input, 11 each: pixel coordinates.
REQ-011 Port lay_hit, input, NUM_LAYERS: per-layer bounding-box hit; index 0 credits, 1 game name, 2 wall, 3 apple, 4 head, 5 body.
REQ-012 Port lay_addr, input, NUM_LAYERS*ADDR_W: per-layer ROM address; layer n occupies bits [n*ADDR_W +: ADDR_W].
REQ-013 Ports rom_addr (output, ADDR_W) and rom_sel (output, 3): shared sprite ROM address and bank select.
REQ-014 Port rom_data, input, PIX_W: sprite ROM read data, available 1 clock after address.
REQ-015 Ports grass_addr (output, 12) and grass_data (input, PIX_W): grass tile ROM, 1-clock read latency.
REQ-016 Ports out_valid (output, 1) and draw_r, draw_g, draw_b (output, 4 each): composited pixel.
REQ-017 Port mode, output, 2: current game mode.
REQ-018 Port evt, output, 3: previous-frame events; bit0 eat (head with apple), bit1 wall (head with wall), bit2 self (head with body).
REQ-019 Port evt_valid, output, 1: one-cycle pulse when evt updates.

Function
REQ-020 Mode FSM encoding: IDLE=0, PLAY=1, WIN=2, LOSE=3; transitions evaluated only on cycles with frame_start=1.
REQ-021 Transitions: IDLE->PLAY if start; PLAY->LOSE if lose; PLAY->WIN if win and not lose; WIN or LOSE->IDLE if win=0 and lose=0; otherwise hold.
REQ-022 A pixel sampled in the same cycle as frame_start uses the post-transition mode.
REQ-023 Layer enable mask: IDLE layers 0-1 only; PLAY all layers; WIN and LOSE none.
REQ-024 Selection: among lay_hit masked by enable, the lowest index wins; rom_sel = winning index; rom_addr = that layer's lay_addr.
REQ-025 grass_addr = {curr_y[5:0], curr_x[5:0]}, forming a 64x64 tile that wraps every 64 pixels.
REQ-026 rom_addr, rom_sel and grass_addr are registered at the pix_valid sample edge k; out_valid and RGB are registered at edge k+2, giving a fixed latency of 2 with no stalls and full throughput.
REQ-027 Composite colour, first matching rule applies: WIN 0x0F0; LOSE 0xF00; any enabled hit with rom_data != 0x000 gives rom_data; otherwise grass_data.
REQ-028 When out_valid=0, draw_r, draw_g and draw_b are 0.
REQ-029 While pix_valid=0, rom_addr, rom_sel and grass_addr hold their previous values.
REQ-030 Event flags are sticky across a frame: eat, wall and self accumulate from raw lay_hit (unmasked) on valid pixels, only while mode is PLAY.
REQ-031 On frame_start, evt is loaded with the accumulated flags, evt_valid pulses, and the accumulators clear.
REQ-032 A hit sampled in the frame_start cycle itself counts toward the new frame.

Reset
REQ-033 With rst=0 at a rising edge: mode=IDLE; rom_addr, rom_sel and grass_addr = 0; out_valid=0; RGB=0; evt=0; evt_valid=0; accumulators cleared; pipeline valid bits cleared.
REQ-034 Reset mid-pipeline discards all in-flight pixels; out_valid stays 0 until 2 clocks after the first post-reset pix_valid.

Structure
REQ-035 Shared package draw_pkg holds the mode encoding, layer index constants, WIN and LOSE colours, and the transparent key 0x000.
REQ-036 One sub-module, layer_prio_enc: a combinational NUM_LAYERS-bit lowest-index priority encoder with any-hit output.

Verification
REQ-037 Reset, then frame_start with start=1, then frame_start with lose=1 -> mode goes 0->1->3, changing only at frame_start edges.
REQ-038 PLAY, lay_hit=6'b011000, head address 0x0123, rom_data=0x0A5 -> rom_sel=3 (apple); out_valid 2 clocks later with RGB 0x0A5.
REQ-039 PLAY, apple hit with rom_data=0x000 and grass_data=0x2C1 at x=70, y=3 -> grass_addr=0x0C6; output 0x2C1.
REQ-040 PLAY, one pixel with lay_hit bits 4 and 5 set, then frame_start -> evt=3'b100 with a single-cycle evt_valid; next frame with no hits -> evt=0.
REQ-041 IDLE, lay_hit=6'b001100 -> no enabled hit; output equals grass_data.
REQ-042 LOSE mode -> every valid pixel outputs 0xF00 regardless of hits.
REQ-043 Assert rst=0 with pixels in flight -> out_valid=0 on the next cycle.
